// File: rtl/rv_pkg.sv
// Definitions shared by the fetch stage and the control unit: fetch FSM
// states, the canonical NOP, and the base opcodes the decoder matches on.
package rv_pkg;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_ISSUE = 2'd2,
        S_HALT  = 2'd3
    } fetch_state_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: instruction-memory request/response channel plus the
// instruction hand-off to the core and the branch controls coming back.
interface instr_fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            instr_valid;
    logic [31:0]     instr;
    logic            instr_ready;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            pc_src;
    logic [XLEN-1:0] imm_ext;
    logic            fetch_fault;

    modport master (
        output imem_req_valid, imem_addr, instr_valid, instr, pc, pc_plus4, fetch_fault,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready, pc_src, imm_ext
    );

    modport slave (
        input  imem_req_valid, imem_addr, instr_valid, instr, pc, pc_plus4, fetch_fault,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready, pc_src, imm_ext
    );

endinterface

// File: rtl/pc_next_calc.sv
// Next-PC arithmetic: sequential or branch target, bit 0 cleared, and a
// flag when the result is not word aligned.
module pc_next_calc #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm_ext,
    input  logic            pc_src,
    output logic [XLEN-1:0] next_pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            misaligned
);

    localparam logic [XLEN-1:0] FOUR    = XLEN'(4);
    localparam logic [XLEN-1:0] BIT0_HI = XLEN'(1);

    logic [XLEN-1:0] target;

    always_comb begin
        pc_plus4   = pc + FOUR;
        target     = pc_src ? (pc + imm_ext) : pc_plus4;
        next_pc    = target & ~BIT0_HI;
        misaligned = target[1];
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, fetches one word at a time from instruction
// memory and holds it for the core until accepted.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_REQ   | request pc from memory, held until accepted
//   S_WAIT  | request accepted, waiting (unbounded) for the response word
//   S_ISSUE | instr/pc valid to the core, waiting for instr_ready
//   S_HALT  | misaligned next-PC seen; idle until reset
module instr_fetch_unit
    import rv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input logic               clk,
    input logic               reset,
    instr_fetch_unit_if.master bus
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic            instr_valid_q, instr_valid_d;
    logic            fault_q, fault_d;

    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] pc_plus4;
    logic            misaligned;

    pc_next_calc #(.XLEN(XLEN)) u_pc_next_calc (
        .pc         (pc_q),
        .imm_ext    (bus.imm_ext),
        .pc_src     (bus.pc_src),
        .next_pc    (next_pc),
        .pc_plus4   (pc_plus4),
        .misaligned (misaligned)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_REQ;
            pc_q          <= RESET_PC;
            instr_q       <= NOP_INSTR;
            instr_valid_q <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            fault_q       <= fault_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        fault_d       = fault_q;

        unique case (state_q)
            S_REQ: begin
                if (bus.imem_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.imem_rsp_valid) begin
                    instr_d       = bus.imem_rsp_data;
                    instr_valid_d = 1'b1;
                    state_d       = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bus.instr_ready) begin
                    pc_d          = next_pc;
                    instr_valid_d = 1'b0;
                    if (misaligned) begin
                        fault_d = 1'b1;
                        state_d = S_HALT;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_HALT: begin
                instr_valid_d = 1'b0;
            end
            default: state_d = S_HALT;
        endcase
    end

    // Suppressed during reset so memory never sees a request from a stale PC.
    assign bus.imem_req_valid = (state_q == S_REQ) && !reset;
    assign bus.imem_addr      = pc_q;
    assign bus.instr_valid    = instr_valid_q;
    assign bus.instr          = instr_q;
    assign bus.pc             = pc_q;
    assign bus.pc_plus4       = pc_plus4;
    assign bus.fetch_fault    = fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: sequential fetch, stalls, branches,
// wraparound, misaligned halt and reset during an outstanding request.
module tb_instr_fetch_unit;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    instr_fetch_unit_if #(.XLEN(32)) bus ();

    instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered with the DUT in S_REQ; leaves it in S_ISSUE holding data.
    task automatic serve(input logic [31:0] exp_addr, input logic [31:0] data, input int stall);
        check_eq("req_valid", 32'(bus.imem_req_valid), 32'd1);
        check_eq("imem_addr", bus.imem_addr, exp_addr);
        bus.imem_req_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            tick();
            check_eq("stall_req_valid", 32'(bus.imem_req_valid), 32'd1);
            check_eq("stall_addr", bus.imem_addr, exp_addr);
            check_eq("stall_instr_valid", 32'(bus.instr_valid), 32'd0);
        end
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        check_eq("wait_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check_eq("wait_instr_valid", 32'(bus.instr_valid), 32'd0);
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = data;
        tick();
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        check_eq("issue_instr_valid", 32'(bus.instr_valid), 32'd1);
        check_eq("issue_instr", bus.instr, data);
        check_eq("issue_pc", bus.pc, exp_addr);
    endtask

    task automatic issue(input logic src, input logic [31:0] imm);
        bus.pc_src      = src;
        bus.imm_ext     = imm;
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        bus.pc_src      = 1'b0;
        bus.imm_ext     = 32'h0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.instr_ready    = 1'b0;
        bus.pc_src         = 1'b0;
        bus.imm_ext        = 32'h0;
        reset = 1'b1;
        tick();
        tick();
        check_eq("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check_eq("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
        check_eq("rst_instr", bus.instr, 32'h0000_0013);
        check_eq("rst_pc", bus.pc, 32'h0);
        check_eq("rst_fault", 32'(bus.fetch_fault), 32'd0);
        reset = 1'b0;
        #1;

        // Zero-wait sequential fetch: instr_valid three cycles after each instr_ready
        serve(32'h0, 32'h0010_0093, 0);
        issue(1'b0, 32'h0);
        check_eq("seq_instr_valid_drop", 32'(bus.instr_valid), 32'd0);
        serve(32'h4, 32'h0020_0113, 0);
        issue(1'b0, 32'h0);
        serve(32'h8, 32'h0030_0193, 0);
        issue(1'b0, 32'h0);

        // Memory stalls 4 cycles; instr_ready asserted meanwhile must be ignored
        bus.instr_ready = 1'b1;
        serve(32'hC, 32'h0040_0213, 4);
        bus.instr_ready = 1'b0;
        check_eq("stall_pc_plus4", bus.pc_plus4, 32'h10);
        issue(1'b0, 32'h0);

        // Branches
        serve(32'h10, 32'h0050_0293, 0);
        check_eq("pc_plus4_10", bus.pc_plus4, 32'h14);
        issue(1'b0, 32'hFFFF_FFF8);
        serve(32'h14, 32'h0060_0313, 0);
        issue(1'b1, 32'hFFFF_FFFC);
        serve(32'h10, 32'h0070_0393, 0);
        issue(1'b1, 32'hFFFF_FFF8);
        serve(32'h08, 32'h0080_0413, 0);
        issue(1'b1, 32'h0);
        serve(32'h08, 32'h0090_0493, 0);

        // Wraparound and spurious response during issue
        issue(1'b1, 32'hFFFF_FFF4);
        serve(32'hFFFF_FFFC, 32'h00A0_0513, 0);
        check_eq("wrap_pc_plus4", bus.pc_plus4, 32'h0);
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'hDEAD_BEEF;
        tick();
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        check_eq("spurious_instr", bus.instr, 32'h00A0_0513);
        check_eq("spurious_instr_valid", 32'(bus.instr_valid), 32'd1);
        issue(1'b0, 32'h0);
        serve(32'h0, 32'h00B0_0593, 0);

        // Misaligned target halts with sticky fault
        issue(1'b1, 32'h20);
        serve(32'h20, 32'h00C0_0613, 0);
        issue(1'b1, 32'h6);
        check_eq("mis_fault", 32'(bus.fetch_fault), 32'd1);
        check_eq("mis_pc", bus.pc, 32'h26);
        check_eq("mis_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check_eq("mis_instr_valid", 32'(bus.instr_valid), 32'd0);
        bus.imem_req_ready = 1'b1;
        repeat (3) tick();
        bus.imem_req_ready = 1'b0;
        check_eq("halt_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check_eq("halt_fault", 32'(bus.fetch_fault), 32'd1);
        check_eq("halt_pc", bus.pc, 32'h26);
        reset = 1'b1;
        tick();
        check_eq("clr_fault", 32'(bus.fetch_fault), 32'd0);
        check_eq("clr_pc", bus.pc, 32'h0);
        reset = 1'b0;
        #1;

        // Reset while in S_WAIT with a response arriving the same cycle
        check_eq("rw_req_valid", 32'(bus.imem_req_valid), 32'd1);
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        check_eq("rw_in_wait", 32'(bus.imem_req_valid), 32'd0);
        reset = 1'b1;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'hBEEF_0000;
        tick();
        reset = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        #1;
        check_eq("rw_instr", bus.instr, 32'h0000_0013);
        check_eq("rw_instr_valid", 32'(bus.instr_valid), 32'd0);
        serve(32'h0, 32'h00D0_0693, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the control unit and decoder in the RISC-V core.
- Owns the PC register and issues word requests to instruction memory over a valid/ready request and valid response interface.
- Holds each fetched instruction stable for the decode/execute logic until the core accepts it.
- Computes the next PC from the core's PCSrc and the immediate branch offset (beq target = PC + ImmExt).

Parameters:
- XLEN, 32, datapath and address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_addr  out  XLEN  word address of request; equals pc.
- imem_rsp_valid  in  1  instruction word returned this cycle.
- imem_rsp_data  in  32  returned instruction word.
- instr_valid  out  1  instr/pc hold a fetched instruction.
- instr  out  32  fetched instruction; op = instr[6:0], funct3 = instr[14:12], funct7 bit = instr[30].
- instr_ready  in  1  core has completed the instruction; advance PC.
- pc  out  XLEN  address of the current instruction.
- pc_plus4  out  XLEN  pc + 4, modulo 2^XLEN (combinational).
- pc_src  in  1  take branch target (Zero & Branch from control unit).
- imm_ext  in  XLEN  sign-extended branch offset.
- fetch_fault  out  1  sticky; set on a misaligned next-PC.

Behaviour:
- Reset values:
  - state = S_REQ; pc = RESET_PC; instr = 32'h0000_0013 (NOP, addi x0,x0,0).
  - instr_valid = 0; fetch_fault = 0; imem_req_valid = 0 during the reset cycle.
- S_REQ:
  - imem_req_valid = 1; imem_addr = pc.
  - If imem_req_ready = 1, go to S_WAIT; otherwise hold, keeping valid and addr stable (no retraction).
- S_WAIT:
  - imem_req_valid = 0.
  - On imem_rsp_valid: instr <= imem_rsp_data and go to S_ISSUE.
  - Memory latency is unbounded.
  - imem_rsp_valid outside S_WAIT is ignored. The memory contract requires a response no earlier than the cycle after acceptance.
- S_ISSUE:
  - instr_valid = 1; instr and pc are stable.
  - On instr_ready:
    - next = pc_src ? pc + imm_ext : pc + 4, wrap modulo 2^XLEN.
    - next[0] is forced to 0.
    - If next[1] = 1: fetch_fault <= 1, pc <= next, go to S_HALT.
    - Otherwise pc <= next and go to S_REQ.
  - pc_src and imm_ext are sampled only in the cycle where instr_ready = 1.
- S_HALT:
  - instr_valid = 0; imem_req_valid = 0.
  - Remains here until reset.
- Latency: minimum 3 cycles per instruction (REQ accepted, RSP the next cycle, ISSUE with instr_ready already high).
- instr_valid is registered; it rises the cycle after the response is captured.
- Reset has priority in every state, including mid-request. The memory shares this reset, so there is no outstanding-response drain.
- instr_ready while instr_valid = 0 is ignored.
- pc_plus4 is always valid from pc; pc = 32'hFFFF_FFFC gives pc_plus4 = 0.
- Branch with imm_ext = 0 (self-loop) re-fetches the same address.

Decomposition:
- Shared package rv_pkg:
  - fetch state enum (S_REQ, S_WAIT, S_ISSUE, S_HALT).
  - NOP_INSTR constant.
  - opcode localparams OP_LW, OP_SW, OP_RTYPE, OP_BRANCH, shared with the control unit.
- One sub-module pc_next_calc (combinational): inputs pc, imm_ext, pc_src; outputs next_pc, pc_plus4, misaligned.

Test Plan:
- Reset then zero-wait memory, 3 sequential words:
  - imem_addr sequence 0x0, 0x4, 0x8.
  - Each instr appears with instr_valid exactly 3 cycles after the prior instr_ready.
- Memory holds imem_req_ready = 0 for 4 cycles:
  - imem_req_valid stays 1 with imem_addr constant throughout.
  - No state advance until ready.
- Branch: pc = 0x10, pc_src = 1, imm_ext = 0xFFFF_FFF8 at instr_ready:
  - Next imem_addr = 0x08.
  - With pc_src = 0, next imem_addr = 0x14.
- Misaligned target: pc = 0x20, pc_src = 1, imm_ext = 0x6:
  - fetch_fault = 1; pc = 0x26.
  - imem_req_valid stays 0 thereafter.
  - A subsequent reset clears fetch_fault and gives pc = RESET_PC.
- Reset asserted in S_WAIT with a response arriving the same cycle:
  - Response is discarded; instr = NOP, instr_valid = 0.
  - First post-reset request has imem_addr = RESET_PC.
- Wrap: pc = 0xFFFF_FFFC, pc_src = 0:
  - pc_plus4 = 0; next imem_addr = 0x0.
  - Spurious imem_rsp_valid during S_ISSUE leaves instr unchanged.
